// File: rtl/fht_stream_io.sv
// fht_stream_io: loads a 1024-sample frame into the FHT bank RAMs in bit-reversed order,
// runs the FHT start/ready handshake, then streams the result out in natural order.
module fht_stream_io #(
   parameter int A_BIT = 8,
   parameter int D_BIT = 16
) (
   input  logic             iCLK_2,
   input  logic             iRESET,
   input  logic             iIN_VALID,
   input  logic [D_BIT-1:0] iIN_DATA,
   output logic             oIN_READY,
   output logic             oWE_IN,
   output logic [1:0]       oBANK_WR,
   output logic [A_BIT-1:0] oADDR_WR,
   output logic [D_BIT-1:0] oDATA_WR,
   output logic             oFHT_START,
   input  logic             iFHT_RDY,
   input  logic             iSOURCE_DATA,
   output logic             oRD_EN,
   output logic [1:0]       oBANK_RD,
   output logic [A_BIT-1:0] oADDR_RD,
   output logic             oRD_SEL,
   input  logic [D_BIT-1:0] iDATA_RD,
   output logic             oOUT_VALID,
   output logic [D_BIT-1:0] oOUT_DATA,
   output logic             oOUT_LAST,
   input  logic             iOUT_READY,
   output logic             oBUSY
);
   localparam int NB = A_BIT + 2;
   localparam logic [NB-1:0] LAST = '1;
   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} state_t;
   state_t state, state_nx;
   logic started, rdy_low, acc, pop, slot, rd_q, rd_last_q;
   logic [NB-1:0] n, r;
   logic [NB:0] k;
   logic [1:0] cnt;
   logic [2:0] commit;
   logic [D_BIT-1:0] f_data [2];
   logic [1:0] f_last;
   always_comb for (int i = 0; i < NB; i++) r[i] = n[NB-1-i];
   assign oIN_READY  = state == LOAD;
   assign oFHT_START = state == START;
   assign oBUSY      = state == START || state == WAIT || state == UNLOAD;
   assign acc        = iIN_VALID && oIN_READY;
   assign oOUT_VALID = cnt != 2'd0;
   assign oOUT_DATA  = f_data[0];
   assign oOUT_LAST  = oOUT_VALID && f_last[0];
   assign pop        = oOUT_VALID && iOUT_READY;
   // words held plus words still coming back from RAM, after this cycle's pop leaves
   assign commit     = {1'b0, cnt} + {2'b0, rd_q} - {2'b0, pop};
   assign oRD_EN     = state == UNLOAD && !k[NB] && commit < 3'd2;
   assign oBANK_RD   = k[NB-1:NB-2];
   assign oADDR_RD   = k[A_BIT-1:0];
   assign slot       = pop ? cnt == 2'd2 : cnt != 2'd0;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = started ? LOAD : IDLE;
         LOAD:    state_nx = acc && n == LAST ? START : LOAD;
         START:   state_nx = WAIT;
         WAIT:    state_nx = iFHT_RDY && rdy_low ? UNLOAD : WAIT;
         UNLOAD:  state_nx = pop && oOUT_LAST ? LOAD : UNLOAD;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge iCLK_2 or negedge iRESET)
      if (!iRESET) begin
         state     <= IDLE;
         started   <= 1'b0;
         rdy_low   <= 1'b0;
         n         <= '0;
         k         <= '0;
         oWE_IN    <= 1'b0;
         oBANK_WR  <= '0;
         oADDR_WR  <= '0;
         oDATA_WR  <= '0;
         oRD_SEL   <= 1'b0;
         rd_q      <= 1'b0;
         rd_last_q <= 1'b0;
         cnt       <= '0;
         f_data    <= '{default: '0};
         f_last    <= '0;
      end else begin
         state     <= state_nx;
         started   <= 1'b1;
         rdy_low   <= state == WAIT && (rdy_low || !iFHT_RDY);
         if (state != LOAD && state_nx == LOAD) n <= '0;
         else if (acc) n <= n + NB'(1);
         oWE_IN    <= acc;
         if (acc) begin
            oBANK_WR <= r[NB-1:NB-2];
            oADDR_WR <= r[A_BIT-1:0];
            oDATA_WR <= iIN_DATA;
         end
         if (state == WAIT && state_nx == UNLOAD) begin
            oRD_SEL <= iSOURCE_DATA;
            k       <= '0;
         end else k <= k + (NB+1)'(oRD_EN);
         rd_q      <= oRD_EN;
         rd_last_q <= oRD_EN && k[NB-1:0] == LAST;
         cnt       <= cnt + {1'b0, rd_q} - {1'b0, pop};
         if (pop) begin
            f_data[0] <= f_data[1];
            f_last[0] <= f_last[1];
         end
         if (rd_q) begin
            f_data[slot] <= iDATA_RD;
            f_last[slot] <= rd_last_q;
         end
      end
endmodule
